game_shot_clock: RTL and testbench
==================================

# game_shot_clock

Countdown timekeeping stage for the basketball system. It sits directly downstream of the free-running one-second tick generator and consumes its single-cycle `tick` strobe. It maintains the period game clock (MM:SS), the 24-second shot clock and the period number, and drives the horn. All outputs are registered and go straight to the display and horn drivers.

## Interface
- `PERIOD_MIN`, default 12: period length in minutes (1–15).
- `SHOT_SEC`, default 24: shot clock reload value in seconds (1–31).
- `NUM_PERIODS`, default 4: number of periods per game (1–7).
- `BUZZ_CYCLES`, default 50: horn pulse length in `clk` cycles (≥1).
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-second strobe, high for exactly one `clk` cycle.
- `start` in 1: level sampled each cycle; run/advance request.
- `stop` in 1: level sampled each cycle; pause request.
- `shot_reset` in 1: reload the shot clock.
- `game_min` out 4: game clock minutes.
- `game_sec` out 6: game clock seconds, 0–59.
- `shot_sec` out 5: shot clock seconds.
- `period` out 3: current period, 1..NUM_PERIODS.
- `running` out 1: high in RUN.
- `shot_violation` out 1: one-cycle pulse.
- `buzzer` out 1: horn drive.
- `game_over` out 1: high in GAME_OVER.

## Operation
- Reset values: state IDLE, `game_min`=PERIOD_MIN, `game_sec`=0, `shot_sec`=SHOT_SEC, `period`=1, and all 1-bit outputs 0.
- States: IDLE, RUN, PAUSE, EXPIRED, GAME_OVER.
- IDLE/PAUSE: `start`=1 and `stop`=0 → RUN.
- RUN: `stop`=1 → PAUSE. On `tick`:
  - game clock decrements: SS>0 → SS−1; SS=0 → SS=59, MM−1.
  - shot clock decrements if >0.
- Game clock reaches 00:00 on a tick:
  - If `period`<NUM_PERIODS → EXPIRED; else → GAME_OVER.
  - Horn fires.
- Shot clock reaches 0 on a tick while game clock ≠00:00:
  - `shot_violation` pulses for 1 cycle.
  - Horn fires; state → PAUSE.
  - `shot_sec` holds 0 until `shot_reset`.
- EXPIRED: `start` → `period`+1, game clock reloads to PERIOD_MIN:00, shot clock reloads to SHOT_SEC, state → IDLE.
- GAME_OVER: `game_over`=1. Only `rst_n` exits this state, and all inputs are ignored.
- `shot_reset`: reloads `shot_sec`=SHOT_SEC in IDLE, RUN and PAUSE. It has no effect on state.
- Horn: a fire event loads a down-counter with BUZZ_CYCLES. `buzzer`=1 while the counter is nonzero. A re-fire during an active pulse restarts the count.
- Arithmetic: unsigned; no underflow past 00:00 or shot 0.
- `tick` outside RUN is ignored.

## Timing
- Outputs update on the `clk` edge that samples `tick`, `start`, `stop` or `shot_reset`, and are visible the following cycle (1-cycle latency).
- `buzzer` rises in the same cycle as the state change into EXPIRED/GAME_OVER/PAUSE-by-violation. It stays high exactly BUZZ_CYCLES cycles.
- Simultaneous events:
  - `start` and `stop` together: stop wins (IDLE/PAUSE stay; RUN → PAUSE).
  - `tick` and `stop` in RUN: the tick is applied, then the state moves to PAUSE in the same edge.
  - `tick` and `shot_reset`: the reload wins, with no shot decrement; the game clock still decrements.
  - Game and shot clocks reach 0 on the same tick: game expiry only; no `shot_violation`, one horn pulse.
- `rst_n` low mid-operation: all registers, including the horn counter, go to reset values immediately (asynchronous). Release is synchronous to `clk`.

## Test plan
- Reset, then `start`, then 60 ticks → `game_min`=11, `game_sec`=0, `shot_sec`=0 after tick 24. `shot_violation` pulses once at tick 24, state PAUSE, `buzzer` high 50 cycles.
- PERIOD_MIN=1 and `shot_reset` asserted every 20 ticks; run 60 ticks → 00:00, EXPIRED, `running`=0, horn 50 cycles. `start` → `period`=2, 01:00, `shot_sec`=24, IDLE.
- NUM_PERIODS=1, PERIOD_MIN=1, run to 00:00 → `game_over`=1. Further `start` and ticks cause no change.
- `start`+`stop` in the same cycle in IDLE → stays IDLE. `tick`+`stop` in RUN at 11:59 → 11:58 and PAUSE.
- `tick`+`shot_reset` at `shot_sec`=5 → `shot_sec`=24 and the game clock decrements.
- `rst_n` pulse low mid-horn at 7:31 → all outputs return to reset values immediately, with `buzzer`=0.

Source files
------------

// File: rtl/game_shot_clock.sv
// game_shot_clock: period game clock, shot clock, period counter and horn for one game
module game_shot_clock #(
  parameter int PERIOD_MIN  = 12,
  parameter int SHOT_SEC    = 24,
  parameter int NUM_PERIODS = 4,
  parameter int BUZZ_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       shot_reset,
  output logic [3:0] game_min,
  output logic [5:0] game_sec,
  output logic [4:0] shot_sec,
  output logic [2:0] period,
  output logic       running,
  output logic       shot_violation,
  output logic       buzzer,
  output logic       game_over
);
  localparam int BW = $clog2(BUZZ_CYCLES + 1);
  localparam logic [4:0] SHOT = 5'(SHOT_SEC);
  localparam logic [3:0] PMIN = 4'(PERIOD_MIN);
  typedef enum logic [2:0] {IDLE, RUN, PAUSE, EXPIRED, GAME_OVER} state_t;
  state_t state, state_n;
  logic [3:0] min_n, dec_min;
  logic [5:0] sec_n, dec_sec;
  logic [4:0] shot_n, dec_shot;
  logic [2:0] period_n;
  logic fire, viol_n, game_end, shot_end;
  logic [BW-1:0] buzz_cnt;
  always_comb begin
    dec_sec  = game_sec != 6'd0 ? game_sec - 6'd1 : (game_min != 4'd0 ? 6'd59 : 6'd0);
    dec_min  = (game_sec == 6'd0 && game_min != 4'd0) ? game_min - 4'd1 : game_min;
    dec_shot = shot_reset ? SHOT : (shot_sec != 5'd0 ? shot_sec - 5'd1 : 5'd0);
    game_end = dec_min == 4'd0 && dec_sec == 6'd0;
    // a reload on the same tick cancels the violation; game expiry outranks it
    shot_end = !shot_reset && shot_sec == 5'd1;
    state_n  = state;
    min_n    = game_min;
    sec_n    = game_sec;
    shot_n   = shot_sec;
    period_n = period;
    fire     = 1'b0;
    viol_n   = 1'b0;
    case (state)
      IDLE, PAUSE: begin
        shot_n  = shot_reset ? SHOT : shot_sec;
        state_n = (start && !stop) ? RUN : state;
      end
      RUN: begin
        min_n  = tick ? dec_min : game_min;
        sec_n  = tick ? dec_sec : game_sec;
        shot_n = tick ? dec_shot : (shot_reset ? SHOT : shot_sec);
        if (tick && game_end) begin
          state_n = int'(period) < NUM_PERIODS ? EXPIRED : GAME_OVER;
          fire    = 1'b1;
        end else if (tick && shot_end) begin
          state_n = PAUSE;
          fire    = 1'b1;
          viol_n  = 1'b1;
        end else if (stop) begin
          state_n = PAUSE;
        end
      end
      EXPIRED: if (start) begin
        period_n = period + 3'd1;
        min_n    = PMIN;
        sec_n    = 6'd0;
        shot_n   = SHOT;
        state_n  = IDLE;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      game_min       <= PMIN;
      game_sec       <= 6'd0;
      shot_sec       <= SHOT;
      period         <= 3'd1;
      running        <= 1'b0;
      shot_violation <= 1'b0;
      game_over      <= 1'b0;
      buzzer         <= 1'b0;
      buzz_cnt       <= '0;
    end else begin
      state          <= state_n;
      game_min       <= min_n;
      game_sec       <= sec_n;
      shot_sec       <= shot_n;
      period         <= period_n;
      running        <= state_n == RUN;
      shot_violation <= viol_n;
      game_over      <= state_n == GAME_OVER;
      buzz_cnt       <= fire ? BW'(BUZZ_CYCLES) : (buzz_cnt != '0 ? buzz_cnt - BW'(1) : '0);
      buzzer         <= fire || buzz_cnt > BW'(1);
    end
  end
endmodule

// File: tb/tb_game_shot_clock.sv
// tb_game_shot_clock: directed checks on a default instance and a short-period, two-period instance
module tb_game_shot_clock;
  logic clk = 0, rst_n = 0, tick = 0, start = 0, stop = 0, shot_reset = 0;
  logic [3:0] d_min, s_min;
  logic [5:0] d_sec, s_sec;
  logic [4:0] d_shot, s_shot;
  logic [2:0] d_per, s_per;
  logic d_run, d_viol, d_buzz, d_go, s_run, s_viol, s_buzz, s_go;
  int vec = 0, bad = 0, vd = 0, vs = 0, n;
  always #5 clk = ~clk;
  game_shot_clock u_d (.clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .shot_reset(shot_reset), .game_min(d_min), .game_sec(d_sec), .shot_sec(d_shot), .period(d_per),
    .running(d_run), .shot_violation(d_viol), .buzzer(d_buzz), .game_over(d_go));
  game_shot_clock #(.PERIOD_MIN(1), .NUM_PERIODS(2)) u_s (.clk(clk), .rst_n(rst_n), .tick(tick),
    .start(start), .stop(stop), .shot_reset(shot_reset), .game_min(s_min), .game_sec(s_sec),
    .shot_sec(s_shot), .period(s_per), .running(s_run), .shot_violation(s_viol), .buzzer(s_buzz),
    .game_over(s_go));
  always @(posedge clk) begin
    if (d_viol) vd <= vd + 1;
    if (s_viol) vs <= vs + 1;
  end
  task drive(input logic t, input logic st, input logic sp, input logic sr);
    tick = t; start = st; stop = sp; shot_reset = sr;
    @(negedge clk);
    tick = 0; start = 0; stop = 0; shot_reset = 0;
  endtask
  task do_reset;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    vd = 0; vs = 0;
  endtask
  task test_reset;
    rst_n = 0;
    #1;
    vec++; if ({d_min, d_sec, d_shot} !== {4'd12, 6'd0, 5'd24}) begin bad++; $display("FAIL reset_clk_d got %h want %h", {d_min, d_sec, d_shot}, {4'd12, 6'd0, 5'd24}); end
    vec++; if ({d_run, d_viol, d_buzz, d_go, d_per} !== 7'b0000_001) begin bad++; $display("FAIL reset_flags_d got %b want 0000001", {d_run, d_viol, d_buzz, d_go, d_per}); end
    vec++; if ({s_min, s_sec, s_shot} !== {4'd1, 6'd0, 5'd24}) begin bad++; $display("FAIL reset_clk_s got %h want %h", {s_min, s_sec, s_shot}, {4'd1, 6'd0, 5'd24}); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  task test_shot_violation;
    do_reset;
    drive(0, 1, 0, 0);
    vec++; if (d_run !== 1'b1) begin bad++; $display("FAIL sv_start running got %b want 1", d_run); end
    repeat (23) drive(1, 0, 0, 0);
    vec++; if ({d_min, d_sec, d_shot} !== {4'd11, 6'd37, 5'd1}) begin bad++; $display("FAIL sv_t23 got %h want %h", {d_min, d_sec, d_shot}, {4'd11, 6'd37, 5'd1}); end
    drive(1, 0, 0, 0);
    vec++; if ({d_min, d_sec, d_shot} !== {4'd11, 6'd36, 5'd0}) begin bad++; $display("FAIL sv_t24 got %h want %h", {d_min, d_sec, d_shot}, {4'd11, 6'd36, 5'd0}); end
    vec++; if ({d_run, d_viol, d_buzz, d_go} !== 4'b0110) begin bad++; $display("FAIL sv_t24_flags got %b want 0110", {d_run, d_viol, d_buzz, d_go}); end
    n = 0;
    while (d_buzz && n < 100) begin n++; drive(0, 0, 0, 0); end
    vec++; if (n !== 50) begin bad++; $display("FAIL sv_horn_len got %0d want 50", n); end
    vec++; if (vd !== 1) begin bad++; $display("FAIL sv_viol_count got %0d want 1", vd); end
    drive(1, 0, 0, 0);
    vec++; if ({d_min, d_sec, d_shot} !== {4'd11, 6'd36, 5'd0}) begin bad++; $display("FAIL sv_pause_tick got %h want %h", {d_min, d_sec, d_shot}, {4'd11, 6'd36, 5'd0}); end
    drive(0, 1, 0, 0);
    repeat (36) drive(1, 0, 0, 0);
    vec++; if ({d_min, d_sec, d_shot, d_run} !== {4'd11, 6'd0, 5'd0, 1'b1}) begin bad++; $display("FAIL sv_t60 got %h want %h", {d_min, d_sec, d_shot, d_run}, {4'd11, 6'd0, 5'd0, 1'b1}); end
    vec++; if (vd !== 1) begin bad++; $display("FAIL sv_no_reviol got %0d want 1", vd); end
  endtask
  task test_start_stop;
    do_reset;
    drive(0, 1, 1, 0);
    vec++; if (d_run !== 1'b0) begin bad++; $display("FAIL ss_idle_both got %b want 0", d_run); end
    drive(1, 0, 0, 0);
    vec++; if ({d_min, d_sec, d_shot} !== {4'd12, 6'd0, 5'd24}) begin bad++; $display("FAIL ss_idle_tick got %h want %h", {d_min, d_sec, d_shot}, {4'd12, 6'd0, 5'd24}); end
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    vec++; if ({d_min, d_sec, d_shot, d_run} !== {4'd11, 6'd59, 5'd23, 1'b1}) begin bad++; $display("FAIL ss_run_tick got %h want %h", {d_min, d_sec, d_shot, d_run}, {4'd11, 6'd59, 5'd23, 1'b1}); end
    drive(1, 0, 1, 0);
    vec++; if ({d_min, d_sec, d_shot, d_run} !== {4'd11, 6'd58, 5'd22, 1'b0}) begin bad++; $display("FAIL ss_tick_stop got %h want %h", {d_min, d_sec, d_shot, d_run}, {4'd11, 6'd58, 5'd22, 1'b0}); end
    drive(1, 1, 1, 0);
    vec++; if ({d_min, d_sec, d_shot, d_run} !== {4'd11, 6'd58, 5'd22, 1'b0}) begin bad++; $display("FAIL ss_pause_both got %h want %h", {d_min, d_sec, d_shot, d_run}, {4'd11, 6'd58, 5'd22, 1'b0}); end
    drive(0, 0, 0, 1);
    vec++; if ({d_shot, d_run} !== {5'd24, 1'b0}) begin bad++; $display("FAIL ss_pause_sr got %h want %h", {d_shot, d_run}, {5'd24, 1'b0}); end
  endtask
  task test_expire;
    do_reset;
    drive(0, 1, 0, 0);
    for (int i = 1; i <= 60; i++) begin
      drive(1, 0, 0, i % 20 == 0 && i < 60);
      if (i == 19) begin
        vec++; if ({s_min, s_sec, s_shot} !== {4'd0, 6'd41, 5'd5}) begin bad++; $display("FAIL ex_t19 got %h want %h", {s_min, s_sec, s_shot}, {4'd0, 6'd41, 5'd5}); end
      end
      if (i == 20) begin
        vec++; if ({s_min, s_sec, s_shot} !== {4'd0, 6'd40, 5'd24}) begin bad++; $display("FAIL ex_tick_sr got %h want %h", {s_min, s_sec, s_shot}, {4'd0, 6'd40, 5'd24}); end
      end
    end
    vec++; if ({s_min, s_sec, s_shot, s_per} !== {4'd0, 6'd0, 5'd4, 3'd1}) begin bad++; $display("FAIL ex_end got %h want %h", {s_min, s_sec, s_shot, s_per}, {4'd0, 6'd0, 5'd4, 3'd1}); end
    vec++; if ({s_run, s_viol, s_buzz, s_go} !== 4'b0010) begin bad++; $display("FAIL ex_flags got %b want 0010", {s_run, s_viol, s_buzz, s_go}); end
    n = 0;
    while (s_buzz && n < 100) begin n++; drive(0, 0, 0, 0); end
    vec++; if (n !== 50) begin bad++; $display("FAIL ex_horn_len got %0d want 50", n); end
    drive(0, 1, 0, 0);
    vec++; if ({s_min, s_sec, s_shot, s_per, s_run} !== {4'd1, 6'd0, 5'd24, 3'd2, 1'b0}) begin bad++; $display("FAIL ex_next got %h want %h", {s_min, s_sec, s_shot, s_per, s_run}, {4'd1, 6'd0, 5'd24, 3'd2, 1'b0}); end
    drive(0, 1, 0, 0);
    vec++; if (s_run !== 1'b1) begin bad++; $display("FAIL ex_idle_start got %b want 1", s_run); end
    for (int i = 1; i <= 60; i++) drive(1, 0, 0, i == 20 || i == 36);
    vec++; if ({s_min, s_sec, s_shot, s_per} !== {4'd0, 6'd0, 5'd0, 3'd2}) begin bad++; $display("FAIL go_end got %h want %h", {s_min, s_sec, s_shot, s_per}, {4'd0, 6'd0, 5'd0, 3'd2}); end
    vec++; if ({s_run, s_viol, s_buzz, s_go} !== 4'b0011) begin bad++; $display("FAIL go_flags got %b want 0011", {s_run, s_viol, s_buzz, s_go}); end
    vec++; if (vs !== 0) begin bad++; $display("FAIL go_no_viol got %0d want 0", vs); end
    n = 0;
    while (s_buzz && n < 100) begin n++; drive(0, 0, 0, 0); end
    vec++; if (n !== 50) begin bad++; $display("FAIL go_horn_len got %0d want 50", n); end
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    vec++; if ({s_min, s_sec, s_shot, s_per} !== {4'd0, 6'd0, 5'd0, 3'd2}) begin bad++; $display("FAIL go_frozen got %h want %h", {s_min, s_sec, s_shot, s_per}, {4'd0, 6'd0, 5'd0, 3'd2}); end
    vec++; if ({s_run, s_viol, s_buzz, s_go} !== 4'b0001) begin bad++; $display("FAIL go_frozen_flags got %b want 0001", {s_run, s_viol, s_buzz, s_go}); end
  endtask
  task test_async_reset;
    do_reset;
    drive(0, 1, 0, 0);
    for (int i = 1; i <= 269; i++) drive(1, 0, 0, (i % 20 == 0 && i <= 240) || i == 245);
    vec++; if ({d_min, d_sec, d_shot} !== {4'd7, 6'd31, 5'd0}) begin bad++; $display("FAIL ar_731 got %h want %h", {d_min, d_sec, d_shot}, {4'd7, 6'd31, 5'd0}); end
    vec++; if ({d_run, d_viol, d_buzz, d_go} !== 4'b0110) begin bad++; $display("FAIL ar_731_flags got %b want 0110", {d_run, d_viol, d_buzz, d_go}); end
    repeat (3) drive(0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    vec++; if ({d_min, d_sec, d_shot, d_per} !== {4'd12, 6'd0, 5'd24, 3'd1}) begin bad++; $display("FAIL ar_clk got %h want %h", {d_min, d_sec, d_shot, d_per}, {4'd12, 6'd0, 5'd24, 3'd1}); end
    vec++; if ({d_run, d_viol, d_buzz, d_go} !== 4'b0000) begin bad++; $display("FAIL ar_flags got %b want 0000", {d_run, d_viol, d_buzz, d_go}); end
    @(negedge clk);
    rst_n = 1;
    repeat (2) drive(0, 0, 0, 0);
    vec++; if (d_buzz !== 1'b0) begin bad++; $display("FAIL ar_horn_after got %b want 0", d_buzz); end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_shot_violation;
    test_start_stop;
    test_expire;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
